// File: rtl/multicycle_seq_pkg.sv
// Shared constants for the multicycle instruction sequencer: state encoding,
// memory opcodes and the retired-instruction counter width.
package multicycle_seq_pkg;

  localparam int unsigned INSTRET_W = 32;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/multicycle_seq_timeout_cnt.sv
// Handshake wait timer (module mc_timeout_cnt): reloads while not waiting,
// counts down while waiting, flags expiry on the last allowed wait cycle.
module mc_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] START = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= START;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = dec && (cnt == '0);

endmodule

// File: rtl/multicycle_seq.sv
// Multicycle fetch/decode/execute/memory/writeback sequencer.
// Optional handshake timeout enabled by defining MC_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | parked, no strobes
// FETCH    | imem_req held until imem_ack; ir_we in ack cycle
// DECODE   | one cycle for decoder settle
// EXEC     | dispatch: mem op, register write, or retire
// MEM      | dmem_req held until dmem_ack
// WB       | rf_we + pc_we for one cycle, retire
module multicycle_seq
  import multicycle_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [6:0]           opcode,
  input  logic                 rf_we_dec,
  output logic                 imem_req,
  input  logic                 imem_ack,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ack,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 rf_we,
  output logic                 busy,
  output logic [INSTRET_W-1:0] instret,
  output logic                 err
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  logic [2:0] state, state_n;
  logic       armed;
  logic       is_store;
  logic       to_expire;

  assign is_store = (opcode == OP_STORE);

  assign imem_req = (state == S_FETCH);
  assign ir_we    = (state == S_FETCH) && imem_ack;
  assign dmem_req = (state == S_MEM);
  assign dmem_we  = (state == S_MEM) && is_store;
  assign rf_we    = (state == S_WB);
  assign busy     = (state != S_IDLE);
  assign pc_we    = (state == S_WB)
                 || ((state == S_EXEC) && !is_mem_op(opcode) && !rf_we_dec)
                 || ((state == S_MEM) && dmem_ack && is_store);

`ifdef MC_TIMEOUT_EN
  logic waiting, ack_now, err_q;

  assign waiting = (state == S_FETCH) || (state == S_MEM);
  assign ack_now = (state == S_FETCH) ? imem_ack : dmem_ack;

  mc_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (!waiting || ack_now),
    .dec    (waiting && !ack_now),
    .expire (to_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (to_expire) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign to_expire = 1'b0;
  assign err       = 1'b0;
`endif

  // armed holds off the first fetch until one full cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      armed   <= 1'b0;
      instret <= '0;
    end else begin
      state <= state_n;
      armed <= 1'b1;
      if (pc_we) begin
        instret <= instret + 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (run && armed) state_n = S_FETCH;
      S_FETCH: begin
        if (imem_ack)       state_n = S_DECODE;
        else if (to_expire) state_n = S_IDLE;
      end
      S_DECODE: state_n = S_EXEC;
      S_EXEC: begin
        if (is_mem_op(opcode)) state_n = S_MEM;
        else if (rf_we_dec)    state_n = S_WB;
        else                   state_n = run ? S_FETCH : S_IDLE;
      end
      S_MEM: begin
        if (dmem_ack)       state_n = is_store ? (run ? S_FETCH : S_IDLE) : S_WB;
        else if (to_expire) state_n = S_IDLE;
      end
      S_WB:     state_n = run ? S_FETCH : S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed self-checking bench for multicycle_seq; covers the MC_TIMEOUT_EN
// build when that macro is defined, the wait-forever build otherwise.
module tb_multicycle_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [6:0]  opcode;
  logic        rf_we_dec;
  logic        imem_req, imem_ack;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        ir_we, pc_we, rf_we, busy, err;
  logic [31:0] instret;
  logic [6:0]  o;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  multicycle_seq #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .rf_we_dec(rf_we_dec),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .busy(busy),
    .instret(instret), .err(err)
  );

  always #5 clk = ~clk;

  // {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, busy}
  assign o = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, busy};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; run = 1'b0; opcode = '0; rf_we_dec = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; run = 1'b1; opcode = OP_ALU; rf_we_dec = 1'b1;
    imem_ack = 1'b1; dmem_ack = 1'b1;
    #2;
    checks++;
    if (o !== 7'b0) begin failures++; $display("FAIL reset_outputs o=%b exp=%b", o, 7'b0); end
    checks++;
    if ({instret, err} !== 33'b0) begin
      failures++; $display("FAIL reset_counters instret=%0d err=%b exp=0/0", instret, err);
    end
    tick; tick;
    rst_n = 1'b1;
    tick;
    #3;
    checks++;
    if (o !== 7'b0) begin failures++; $display("FAIL reset_first_edge o=%b exp=%b", o, 7'b0); end
    tick;
    #3;
    checks++;
    if (o !== 7'b1100001) begin failures++; $display("FAIL reset_second_edge o=%b exp=%b", o, 7'b1100001); end
  endtask

  task automatic test_alu;
    logic [6:0] exp [5] = '{7'b1100001, 7'b0000001, 7'b0000001, 7'b0000111, 7'b0000000};
    do_reset;
    opcode = OP_ALU; rf_we_dec = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    run = 1'b1;
    tick;
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      checks++;
      if (o !== exp[i]) begin failures++; $display("FAIL alu cyc%0d o=%b exp=%b", i, o, exp[i]); end
      tick;
    end
    checks++;
    if (instret !== 32'd1) begin failures++; $display("FAIL alu_instret got=%0d exp=1", instret); end
  endtask

  task automatic test_load;
    logic [6:0] exp [9] = '{7'b1100001, 7'b0000001, 7'b0000001, 7'b0010001, 7'b0010001,
                            7'b0010001, 7'b0010001, 7'b0000111, 7'b0000000};
    do_reset;
    opcode = OP_LD; rf_we_dec = 1'b1; imem_ack = 1'b1;
    run = 1'b1;
    tick;
    run = 1'b0;
    for (int i = 0; i < 9; i++) begin
      dmem_ack = (i == 6);
      #3;
      checks++;
      if (o !== exp[i]) begin failures++; $display("FAIL load cyc%0d o=%b exp=%b", i, o, exp[i]); end
      tick;
    end
    checks++;
    if (instret !== 32'd1) begin failures++; $display("FAIL load_instret got=%0d exp=1", instret); end
  endtask

  task automatic test_store;
    logic [6:0] exp [5] = '{7'b1100001, 7'b0000001, 7'b0000001, 7'b0011011, 7'b0000000};
    do_reset;
    opcode = OP_ST; rf_we_dec = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    run = 1'b1;
    tick;
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      checks++;
      if (o !== exp[i]) begin failures++; $display("FAIL store cyc%0d o=%b exp=%b", i, o, exp[i]); end
      tick;
    end
    checks++;
    if (instret !== 32'd1) begin failures++; $display("FAIL store_instret got=%0d exp=1", instret); end
  endtask

  task automatic test_branch;
    logic [6:0] exp [4] = '{7'b1100001, 7'b0000001, 7'b0000011, 7'b0000000};
    do_reset;
    opcode = OP_BR; rf_we_dec = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b0;
    run = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) run = 1'b0;
      #3;
      checks++;
      if (o !== exp[i]) begin failures++; $display("FAIL branch cyc%0d o=%b exp=%b", i, o, exp[i]); end
      tick;
    end
    #3;
    checks++;
    if ({busy, instret} !== {1'b0, 32'd1}) begin
      failures++; $display("FAIL branch_idle busy=%b instret=%0d exp=0/1", busy, instret);
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp [9] = '{7'b1100001, 7'b0000001, 7'b0000001, 7'b0000111, 7'b1000001,
                            7'b1100001, 7'b0000001, 7'b0000011, 7'b0000000};
    do_reset;
    dmem_ack = 1'b0;
    run = 1'b1;
    tick;
    for (int i = 0; i < 9; i++) begin
      imem_ack  = (i != 4);
      opcode    = (i < 4) ? OP_ALU : 7'b0000000;
      rf_we_dec = (i < 4);
      run       = (i < 7);
      #3;
      checks++;
      if (o !== exp[i]) begin failures++; $display("FAIL b2b cyc%0d o=%b exp=%b", i, o, exp[i]); end
      tick;
    end
    checks++;
    if (instret !== 32'd2) begin failures++; $display("FAIL b2b_instret got=%0d exp=2", instret); end
  endtask

  task automatic test_reset_mid_mem;
    logic [6:0] exp [8] = '{7'b1100001, 7'b0000001, 7'b0000001, 7'b0000111,
                            7'b1100001, 7'b0000001, 7'b0000001, 7'b0010001};
    do_reset;
    imem_ack = 1'b1; dmem_ack = 1'b0;
    run = 1'b1;
    tick;
    for (int i = 0; i < 8; i++) begin
      opcode    = (i < 4) ? OP_ALU : OP_LD;
      rf_we_dec = 1'b1;
      run       = (i < 4);
      #3;
      checks++;
      if (o !== exp[i]) begin failures++; $display("FAIL rstmem cyc%0d o=%b exp=%b", i, o, exp[i]); end
      tick;
    end
    checks++;
    if (instret !== 32'd1) begin failures++; $display("FAIL rstmem_pre_instret got=%0d exp=1", instret); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({o, instret, err} !== 40'b0) begin
      failures++; $display("FAIL rstmem_async o=%b instret=%0d err=%b exp=0", o, instret, err);
    end
    dmem_ack = 1'b1;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      #3;
      checks++;
      if ({o, instret} !== 39'b0) begin
        failures++; $display("FAIL rstmem_late_ack cyc%0d o=%b instret=%0d exp=0", i, o, instret);
      end
    end
  endtask

  task automatic test_timeout;
    int n;
    do_reset;
    opcode = OP_BR; rf_we_dec = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    run = 1'b1;
    tick;
    n = 0;
`ifdef MC_TIMEOUT_EN
    run = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #3;
      if (!busy) break;
      if (imem_req) n++;
      tick;
    end
    checks++;
    if (n !== 16) begin failures++; $display("FAIL timeout_fetch_cycles got=%0d exp=16", n); end
    checks++;
    if ({err, busy, imem_req, instret} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      failures++; $display("FAIL timeout_state err=%b busy=%b req=%b instret=%0d exp=1/0/0/0",
                           err, busy, imem_req, instret);
    end
    imem_ack = 1'b1;
    tick; tick; tick;
    #3;
    checks++;
    if ({err, busy} !== 2'b10) begin
      failures++; $display("FAIL timeout_sticky err=%b busy=%b exp=1/0", err, busy);
    end
    do_reset;
    #3;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL timeout_err_clear got=%b exp=0", err); end
`else
    for (int k = 0; k < 30; k++) begin
      #3;
      if (imem_req && !err) n++;
      tick;
    end
    checks++;
    if (n !== 30) begin failures++; $display("FAIL wait_forever_cycles got=%0d exp=30", n); end
    run = 1'b0;
    imem_ack = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      #3;
      if (!busy) break;
      n++;
      tick;
    end
    checks++;
    if (n !== 3) begin failures++; $display("FAIL wait_forever_finish busy_cycles=%0d exp=3", n); end
    checks++;
    if ({instret, err} !== {32'd1, 1'b0}) begin
      failures++; $display("FAIL wait_forever_instret instret=%0d err=%b exp=1/0", instret, err);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_alu;
    test_load;
    test_store;
    test_branch;
    test_back_to_back;
    test_reset_mid_mem;
    test_timeout;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
